// File: rtl/mem_port_arbiter.sv
// Arbitrates one slow memory port between I-cache and D-cache.
// D has priority; a streak counter guarantees I-fetch progress.
module mem_port_arbiter #(
   parameter int ADDR_W       = 28,
   parameter int DATA_W       = 128,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] MAX_S = SW'(MAX_D_STREAK);

   state_t            state_q, state_d;
   logic [SW-1:0]     d_streak_q, d_streak_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_ready_q, i_ready_d;
   logic              d_ready_q, d_ready_d;

   logic d_req, i_starved, grant_d, grant_i;

   // D wins unless I has waited through a full D streak
   assign d_req     = d_read | d_write;
   assign i_starved = i_read && (d_streak_q >= MAX_S);
   assign grant_d   = d_req && !i_starved;
   assign grant_i   = !grant_d && i_read;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (grant_d)      state_d = BUSY_D;
            else if (grant_i) state_d = BUSY_I;
         end
         BUSY_I, BUSY_D: if (mem_ready) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      d_streak_d  = d_streak_q;
      unique case (state_q)
         IDLE: begin
            if (grant_d) begin
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_write_d = d_write;
               mem_read_d  = !d_write;
               if (!i_read)
                  d_streak_d = '0;
               else if (d_streak_q != MAX_S)
                  d_streak_d = d_streak_q + SW'(1);
            end else if (grant_i) begin
               mem_addr_d  = i_addr;
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
               d_streak_d  = '0;
            end
         end
         BUSY_I: begin
            if (mem_ready) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               i_rdata_d   = mem_rdata;
               i_ready_d   = 1'b1;
            end
         end
         BUSY_D: begin
            if (mem_ready) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               d_rdata_d   = mem_rdata;
               d_ready_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_streak_q  <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
      end else begin
         d_streak_q  <= d_streak_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
      end
   end

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign i_ready   = i_ready_q;
   assign d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_D_STREAK=2).
// Bench plays both caches and the memory model.
module tb_mem_port_arbiter;

   localparam int AW = 28;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read, d_read, d_write, mem_ready;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata, mem_rdata;
   logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
   logic          i_ready, d_ready, mem_read, mem_write;
   logic [AW-1:0] mem_addr;

   int checks = 0;
   int errors = 0;

   localparam logic [DW-1:0] R1 = {4{32'hDEADBEEF}};
   localparam logic [DW-1:0] W2 = {4{32'h12345678}};
   localparam logic [DW-1:0] R3 = {4{32'hA5A5_0003}};
   localparam logic [DW-1:0] R4 = {4{32'hC3C3_0004}};
   localparam logic [DW-1:0] R5 = {4{32'h0F0F_0005}};

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(2)
   ) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr),
      .i_rdata(i_rdata), .i_ready(i_ready),
      .d_read(d_read), .d_write(d_write),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_strobe(input string tag);
      int n = 0;
      while (!(mem_read || mem_write) && n < 10) begin
         tick();
         n++;
      end
      chk(tag, {127'd0, mem_read | mem_write}, 1);
   endtask

   int pulses;
   int strobes;
   string order;

   initial begin
      rst = 1'b1; i_read = 0; d_read = 0; d_write = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      mem_ready = 0; mem_rdata = '0;
      tick(); tick();
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_readys", {i_ready, d_ready}, 0);
      chk("rst_rdata", i_rdata | d_rdata, 0);
      rst = 1'b0;
      tick();

      // I-only read, memory answers after 3 cycles
      i_read = 1; i_addr = 28'h0000010;
      tick();
      chk("i_strobe", {mem_write, mem_read}, 2'b01);
      chk("i_addr", mem_addr, 28'h0000010);
      tick(); tick();
      chk("i_hold", mem_read, 1);
      mem_ready = 1; mem_rdata = R1;
      tick();
      chk("i_ready", i_ready, 1);
      chk("i_rdata", i_rdata, R1);
      chk("i_no_d", d_ready, 0);
      chk("i_drop", mem_read, 0);
      mem_ready = 0; i_read = 0;
      tick();
      chk("i_pulse_end", i_ready, 0);
      chk("i_rdata_hold", i_rdata, R1);
      tick();

      // D write-back, requester drops during BUSY
      d_write = 1; d_addr = 28'h0000020; d_wdata = W2;
      mem_rdata = '0;
      tick();
      chk("dw_strobe", {mem_write, mem_read}, 2'b10);
      chk("dw_addr", mem_addr, 28'h0000020);
      chk("dw_wdata", mem_wdata, W2);
      d_write = 0; d_wdata = '0;
      tick();
      chk("dw_hold", {mem_write, mem_read}, 2'b10);
      chk("dw_wdata_hold", mem_wdata, W2);
      mem_ready = 1;
      tick();
      chk("dw_ready", {i_ready, d_ready}, 2'b01);
      chk("dw_drop", mem_write, 0);
      mem_ready = 0;
      tick();
      chk("dw_pulse_end", d_ready, 0);
      tick();

      // Simultaneous I and D reads: D first, I two cycles after d_ready
      i_read = 1; i_addr = 28'h0000030;
      d_read = 1; d_addr = 28'h0000040;
      tick();
      chk("sim_d_first", mem_addr, 28'h0000040);
      chk("sim_d_read", {mem_write, mem_read}, 2'b01);
      d_read = 0;
      tick();
      mem_ready = 1; mem_rdata = R3;
      tick();
      chk("sim_d_ready", {i_ready, d_ready}, 2'b01);
      chk("sim_d_rdata", d_rdata, R3);
      mem_ready = 0;
      tick();
      chk("sim_gap", {mem_read, d_ready}, 2'b00);
      tick();
      chk("sim_i_strobe", mem_read, 1);
      chk("sim_i_addr", mem_addr, 28'h0000030);
      mem_ready = 1; mem_rdata = R4;
      tick();
      chk("sim_i_ready", {i_ready, d_ready}, 2'b10);
      chk("sim_i_rdata", i_rdata, R4);
      chk("sim_d_keep", d_rdata, R3);
      mem_ready = 0; i_read = 0;
      tick(); tick();

      // Starvation guard with both requests held high
      i_read = 1; i_addr = 28'h0000050;
      d_read = 1; d_addr = 28'h0000060;
      order = "";
      for (int g = 0; g < 6; g++) begin
         wait_strobe($sformatf("stv_strobe%0d", g));
         order = {order, (mem_addr == 28'h0000050) ? "I" : "D"};
         mem_ready = 1; mem_rdata = R5;
         tick();
         chk($sformatf("stv_one_ready%0d", g),
             {127'd0, i_ready ^ d_ready}, 1);
         mem_ready = 0;
         tick();
      end
      i_read = 0; d_read = 0;
      checks++;
      assert (order == "DDIDDI") else begin
         errors++;
         $error("FAIL stv_order observed=%s expected=DDIDDI", order);
      end
      tick(); tick();

      // mem_ready held 4 cycles: single pulse, no extra transaction
      i_read = 1; i_addr = 28'h0000070;
      tick();
      chk("hold_strobe", mem_read, 1);
      i_read = 0;
      mem_ready = 1; mem_rdata = R5;
      pulses = 0; strobes = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         pulses += int'(i_ready) + int'(d_ready);
         strobes += int'(mem_read) + int'(mem_write);
      end
      mem_ready = 0;
      tick();
      chk("hold_pulses", pulses, 1);
      chk("hold_strobes", strobes, 0);
      chk("hold_rdata", i_rdata, R5);

      // Reset two cycles after a D write grant
      d_write = 1; d_addr = 28'h0000080; d_wdata = W2;
      tick();
      chk("rb_strobe", mem_write, 1);
      d_write = 0;
      tick();
      rst = 1;
      tick();
      rst = 0;
      chk("rb_write", mem_write, 0);
      chk("rb_ready", d_ready, 0);
      chk("rb_addr", mem_addr, 0);
      mem_ready = 1;
      tick();
      chk("rb_late_ready", {i_ready, d_ready, mem_read, mem_write}, 0);
      mem_ready = 0;
      i_read = 1; i_addr = 28'h0000090;
      tick();
      chk("rb_i_strobe", {mem_write, mem_read}, 2'b01);
      chk("rb_i_addr", mem_addr, 28'h0000090);
      mem_ready = 1; mem_rdata = R1;
      tick();
      chk("rb_i_ready", {i_ready, d_ready}, 2'b10);
      chk("rb_i_rdata", i_rdata, R1);
      mem_ready = 0; i_read = 0;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single slow memory port between the instruction cache and the data cache of the pipelined CPU with branch predictor.
- Data-cache requests take priority, bounded by an anti-starvation counter that guarantees instruction fetch progress.
- Sits between both caches and the memory model used by the testbench.
- Provides registered one-transaction-at-a-time sequencing with a one-cycle ready pulse back to the owner.

Parameters:
- ADDR_W, 28, line address width (word address bits [29:2]).
- DATA_W, 128, cache line width in bits.
- MAX_D_STREAK, 4, consecutive D grants allowed while an I request is pending; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_read  in  1  I-cache line read request; held until i_ready.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  DATA_W  line returned to I-cache; valid while i_ready=1.
- i_ready  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request.
- d_write  in  1  D-cache line write (write-back) request.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  DATA_W  write-back line.
- d_rdata  out  DATA_W  line returned to D-cache; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready.
- mem_ready  in  1  memory completion; may stay high more than one cycle.

Behaviour:
- All outputs are registered. On rst, all outputs are 0, state is IDLE, and d_streak is 0.
- Reset mid-transaction abandons the transaction. mem_read/mem_write are 0 in the cycle after the rst edge, and no ready pulse is issued.
- States:
  - IDLE: sample requests.
    - If d_req=(d_read|d_write) and NOT (i_read and d_streak≥MAX_D_STREAK), grant D.
    - Else if i_read, grant I.
    - Else stay in IDLE.
  - On grant: capture owner's addr (and wdata, op) into mem_addr/mem_wdata, assert mem_read or mem_write, then go to BUSY_I or BUSY_D.
  - d_read and d_write both high: treated as write; the read is ignored.
  - BUSY_x: hold mem_* stable and ignore requester inputs. When mem_ready=1, drop mem_read/mem_write, latch mem_rdata into x_rdata, set x_ready=1, and go to RESP.
  - RESP: lasts one cycle. x_ready=1 this cycle only, then 0. Go to IDLE; mem_ready is ignored here.
- Latency: request high in IDLE at cycle t gives mem strobe high at t+1. mem_ready high at cycle u gives x_ready high at u+1. The earliest next grant is sampled at u+2 (mem strobe at u+3).
- x_rdata holds its value until the next completion to the same requester. For D writes, d_rdata is updated with mem_rdata (don't-care content), and d_ready still pulses.
- Requester dropping its request during BUSY: the transaction still completes and ready still pulses.
- d_streak updates on each grant:
  - D grant with i_read=1: increment, saturating at MAX_D_STREAK.
  - D grant with i_read=0: reset to 0.
  - I grant: reset to 0.
- The arbiter never drives mem_read and mem_write simultaneously. It never drives both ready outputs in the same cycle.

Test Plan:
- I-only read: i_read=1, i_addr=0x0000010 at t; memory returns 0xDEADBEEF_... after 3 cycles → mem_read=1/mem_addr=0x0000010 at t+1; i_ready=1 with i_rdata=0xDEADBEEF_... for exactly one cycle; d_ready stays 0.
- D write-back: d_write=1, d_addr=0x0000020, d_wdata=0x1234_... → mem_write=1, mem_wdata=0x1234_... held until mem_ready; d_ready pulse one cycle; mem_read never asserted.
- Simultaneous: i_read and d_read both high in IDLE → D transaction first (mem_addr=d_addr). After d_ready, I transaction starts with mem strobe two cycles later.
- Starvation: MAX_D_STREAK=2, i_read held high, D re-requests immediately after each d_ready → grant order D,D,I,D,D,I; d_streak returns to 0 after each I grant.
- mem_ready held high 4 cycles: exactly one ready pulse. No spurious second transaction unless a request is present in IDLE.
- Reset mid-BUSY_D: assert rst for one cycle two cycles after grant → mem_write=0, d_ready=0, state IDLE. A later i_read is then served normally.
